// File: rtl/axi_crossbar_slv_switch_n_if.sv
// Channel bundle for the crossbar slave switch. N lanes of AW/W/AR handshakes and payloads;
// the B/R payloads are single broadcast buses. The master modport is the view of whoever issues requests.
interface axi_crossbar_slv_switch_n_if #(
    parameter int N      = 1,
    parameter int AWCH_W = 49,
    parameter int WCH_W  = 43,
    parameter int BCH_W  = 8,
    parameter int ARCH_W = 49,
    parameter int RCH_W  = 41
);
    logic [N-1:0]        awvalid;
    logic [N-1:0]        awready;
    logic [N*AWCH_W-1:0] awch;
    logic [N-1:0]        wvalid;
    logic [N-1:0]        wready;
    logic [N-1:0]        wlast;
    logic [N*WCH_W-1:0]  wch;
    logic [N-1:0]        bvalid;
    logic [N-1:0]        bready;
    logic [BCH_W-1:0]    bch;
    logic [N-1:0]        arvalid;
    logic [N-1:0]        arready;
    logic [N*ARCH_W-1:0] arch;
    logic [N-1:0]        rvalid;
    logic [N-1:0]        rready;
    logic [N-1:0]        rlast;
    logic [RCH_W-1:0]    rch;

    modport master (
        output awvalid, awch, wvalid, wlast, wch, bready, arvalid, arch, rready,
        input  awready, wready, bvalid, bch, arready, rvalid, rlast, rch
    );

    modport slave (
        input  awvalid, awch, wvalid, wlast, wch, bready, arvalid, arch, rready,
        output awready, wready, bvalid, bch, arready, rvalid, rlast, rch
    );
endinterface

// File: rtl/axi_crossbar_slv_switch_n.sv
// Per-slave crossbar switch: locked round-robin AW/AR arbitration, W steering by a write-order FIFO,
// and tag-based B/R routing. Define AXI_XBAR_SLV_W_BYPASS_EN to forward W in the AW acceptance cycle.
module axi_crossbar_slv_switch_n_arb #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          gate,
    input  logic          ready,
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid,
    output logic          hs
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] pick;
    logic          found;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N) sum = sum - N;
        return sum[IW-1:0];
    endfunction

    // Scan downward so the nearest requester after ptr is the last one written.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                pick  = wrap_add(ptr, i);
                found = 1'b1;
            end
        end
        idx   = (state == LOCKED) ? grant_q : pick;
        valid = en & ~gate & ((state == LOCKED) ? req[grant_q] : found);
        hs    = valid & ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= IW'(N - 1);
            grant_q <= '0;
        end else begin
            if (hs) ptr <= idx;
            case (state)
                IDLE: begin
                    if (valid && !ready) begin
                        state   <= LOCKED;
                        grant_q <= pick;
                    end
                end
                default: begin
                    if (hs) state <= IDLE;
                end
            endcase
        end
    end
endmodule

module axi_crossbar_slv_switch_n #(
    parameter int MST_NB      = 3,
    parameter int AXI_ID_W    = 4,
    parameter int MST_TAG_W   = 2,
    parameter int AWCH_W      = 49,
    parameter int WCH_W       = 43,
    parameter int BCH_W       = 8,
    parameter int ARCH_W      = 49,
    parameter int RCH_W       = 41,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    axi_crossbar_slv_switch_n_if.slave    mst,
    axi_crossbar_slv_switch_n_if.master   slv
);
    localparam int IW = $clog2(MST_NB);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = PW + 1;

    logic          en_q;
    logic [IW-1:0] aw_idx;
    logic [IW-1:0] ar_idx;
    logic          aw_valid;
    logic          aw_hs;
    logic          ar_valid;
    logic          ar_hs;

    logic [IW-1:0] fifo_mem [WFIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [IW-1:0] head;
    logic [IW-1:0] w_src;
    logic          w_sel;
    logic          w_beat_last;
    logic          push;
    logic          pop;

    logic [BCH_W-1:0]     b_chan;
    logic [RCH_W-1:0]     r_chan;
    logic [MST_TAG_W-1:0] b_tag;
    logic [MST_TAG_W-1:0] r_tag;

    // Holds every grant-driven output low from reset assertion until the first clock after release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) en_q <= 1'b0;
        else          en_q <= 1'b1;
    end

    axi_crossbar_slv_switch_n_arb #(.N(MST_NB)) aw_arb (
        .clk(aclk), .rst_n(aresetn), .en(en_q), .gate(fifo_full), .ready(slv.awready[0]),
        .req(mst.awvalid), .idx(aw_idx), .valid(aw_valid), .hs(aw_hs)
    );

    axi_crossbar_slv_switch_n_arb #(.N(MST_NB)) ar_arb (
        .clk(aclk), .rst_n(aresetn), .en(en_q), .gate(1'b0), .ready(slv.arready[0]),
        .req(mst.arvalid), .idx(ar_idx), .valid(ar_valid), .hs(ar_hs)
    );

    assign slv.awvalid = aw_valid;
    assign slv.awch    = mst.awch[aw_idx*AWCH_W +: AWCH_W];
    assign slv.arvalid = ar_valid;
    assign slv.arch    = mst.arch[ar_idx*ARCH_W +: ARCH_W];

    always_comb begin
        mst.awready = '0;
        mst.arready = '0;
        for (int k = 0; k < MST_NB; k++) begin
            mst.awready[k] = aw_valid & slv.awready[0] & (aw_idx == IW'(k));
            mst.arready[k] = ar_valid & slv.arready[0] & (ar_idx == IW'(k));
        end
    end

    assign fifo_full  = (count == CW'(WFIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

`ifdef AXI_XBAR_SLV_W_BYPASS_EN
    // An empty FIFO lets the master being accepted on AW drive W in the same cycle; a
    // single-beat burst finished here never needs to be remembered.
    assign w_sel = en_q & (~fifo_empty | aw_hs);
    assign w_src = fifo_empty ? aw_idx : head;
    assign push  = aw_hs & ~(fifo_empty & w_beat_last);
`else
    assign w_sel = en_q & ~fifo_empty;
    assign w_src = head;
    assign push  = aw_hs;
`endif

    assign pop         = ~fifo_empty & w_beat_last;
    assign slv.wvalid  = w_sel & mst.wvalid[w_src];
    assign slv.wlast   = mst.wlast[w_src];
    assign slv.wch     = mst.wch[w_src*WCH_W +: WCH_W];
    assign w_beat_last = slv.wvalid[0] & slv.wready[0] & slv.wlast[0];

    always_comb begin
        mst.wready = '0;
        for (int k = 0; k < MST_NB; k++) begin
            mst.wready[k] = w_sel & slv.wready[0] & (w_src == IW'(k));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr] <= aw_idx;
    end

    assign b_chan  = slv.bch;
    assign r_chan  = slv.rch;
    assign b_tag   = b_chan[AXI_ID_W-1 -: MST_TAG_W];
    assign r_tag   = r_chan[AXI_ID_W-1 -: MST_TAG_W];
    assign mst.bch = b_chan;
    assign mst.rch = r_chan;

    // A response whose tag names no master is accepted anyway so the slave never stalls on it.
    always_comb begin
        mst.bvalid = '0;
        mst.rvalid = '0;
        mst.rlast  = '0;
        slv.bready = 1'b1;
        slv.rready = 1'b1;
        for (int k = 0; k < MST_NB; k++) begin
            mst.bvalid[k] = slv.bvalid[0] & (b_tag == MST_TAG_W'(k + 1));
            mst.rvalid[k] = slv.rvalid[0] & (r_tag == MST_TAG_W'(k + 1));
            mst.rlast[k]  = slv.rlast[0]  & (r_tag == MST_TAG_W'(k + 1));
            if (b_tag == MST_TAG_W'(k + 1)) slv.bready = mst.bready[k];
            if (r_tag == MST_TAG_W'(k + 1)) slv.rready = mst.rready[k];
        end
    end
endmodule

// File: tb/tb_axi_crossbar_slv_switch_n.sv
// Directed bench for axi_crossbar_slv_switch_n: arbitration order, AW locking, W-FIFO ordering and
// gating, B/R tag routing and reset behaviour, with hand-computed expectations.
module tb_axi_crossbar_slv_switch_n;
    logic aclk    = 1'b0;
    logic aresetn = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    logic [2:0]  exp_ready [4];
    logic [48:0] exp_awch  [4];

    axi_crossbar_slv_switch_n_if #(.N(3)) mst_bus ();
    axi_crossbar_slv_switch_n_if #(.N(1)) slv_bus ();

    axi_crossbar_slv_switch_n dut (
        .aclk(aclk), .aresetn(aresetn), .mst(mst_bus), .slv(slv_bus)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] awv, input logic [2:0] wv, input logic [2:0] wl);
        mst_bus.awvalid = awv;
        mst_bus.wvalid  = wv;
        mst_bus.wlast   = wl;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        mst_bus.awvalid = '0; mst_bus.awch = {49'd302, 49'd301, 49'd300};
        mst_bus.wvalid  = '0; mst_bus.wlast = '0; mst_bus.wch = {43'd102, 43'd101, 43'd100};
        mst_bus.bready  = '0; mst_bus.rready = '0;
        mst_bus.arvalid = '0; mst_bus.arch = {49'd402, 49'd401, 49'd400};
        slv_bus.awready = '0; slv_bus.wready = '0; slv_bus.arready = '0;
        slv_bus.bvalid  = '0; slv_bus.bch = '0;
        slv_bus.rvalid  = '0; slv_bus.rlast = '0; slv_bus.rch = '0;

        // Reset: grant outputs low even with requests pending, B path stays live
        #1 aresetn = 1'b0;
        slv_bus.bvalid = 1'b1; slv_bus.bch = 8'h04; mst_bus.bready = 3'b001;
        slv_bus.awready = 1'b1;
        applyStimulus(3'b111, 3'b000, 3'b000);
        checkOutput("rst_awvalid", 64'(slv_bus.awvalid), 64'd0);
        checkOutput("rst_awready", 64'(mst_bus.awready), 64'd0);
        checkOutput("rst_wvalid",  64'(slv_bus.wvalid),  64'd0);
        checkOutput("rst_bvalid",  64'(mst_bus.bvalid),  64'b001);
        checkOutput("rst_bready",  64'(slv_bus.bready),  64'd1);
        nextCycle();
        nextCycle();
        aresetn = 1'b1;
        slv_bus.bvalid = 1'b0;
        nextCycle();

        // Round robin 0,1,2,0 fills the FIFO
        exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_awch  = '{49'd300, 49'd301, 49'd302, 49'd300};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b111, 3'b000, 3'b000);
            checkOutput("rr_awready", 64'(mst_bus.awready), 64'(exp_ready[i]));
            checkOutput("rr_awch",    64'(slv_bus.awch),    64'(exp_awch[i]));
            nextCycle();
        end
        applyStimulus(3'b111, 3'b000, 3'b000);
        checkOutput("full_awvalid", 64'(slv_bus.awvalid), 64'd0);
        checkOutput("full_awready", 64'(mst_bus.awready), 64'd0);

        // One wlast pops head 0; gating still holds in the pop cycle
        slv_bus.wready = 1'b1;
        applyStimulus(3'b111, 3'b001, 3'b001);
        checkOutput("pop_wvalid",    64'(slv_bus.wvalid),  64'd1);
        checkOutput("pop_wready",    64'(mst_bus.wready),  64'b001);
        checkOutput("pop_wch",       64'(slv_bus.wch),     64'd100);
        checkOutput("pop_awvalid",   64'(slv_bus.awvalid), 64'd0);
        nextCycle();
        applyStimulus(3'b111, 3'b000, 3'b000);
        checkOutput("fifth_awready", 64'(mst_bus.awready), 64'b010);
        nextCycle();

        // Drain in AW acceptance order 1,2,0,1
        exp_ready = '{3'b010, 3'b100, 3'b001, 3'b010};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b000, 3'b111, 3'b111);
            checkOutput("drain_wready", 64'(mst_bus.wready), 64'(exp_ready[i]));
            nextCycle();
        end
        applyStimulus(3'b000, 3'b111, 3'b111);
        checkOutput("empty_wvalid", 64'(slv_bus.wvalid), 64'd0);
        checkOutput("empty_wready", 64'(mst_bus.wready), 64'd0);

        // Locked grant: master 1 stalled three cycles while master 0 joins
        slv_bus.awready = 1'b0;
        applyStimulus(3'b010, 3'b000, 3'b000);
        checkOutput("lock_awch0", 64'(slv_bus.awch), 64'd301);
        nextCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(3'b011, 3'b000, 3'b000);
            checkOutput("lock_awch",    64'(slv_bus.awch),    64'd301);
            checkOutput("lock_awready", 64'(mst_bus.awready), 64'd0);
            nextCycle();
        end
        slv_bus.awready = 1'b1;
        applyStimulus(3'b011, 3'b000, 3'b000);
        checkOutput("lock_hs", 64'(mst_bus.awready), 64'b010);
        nextCycle();
        applyStimulus(3'b001, 3'b000, 3'b000);
        checkOutput("after_lock_awready", 64'(mst_bus.awready), 64'b001);
        checkOutput("after_lock_awch",    64'(slv_bus.awch),    64'd300);
        nextCycle();
        applyStimulus(3'b000, 3'b111, 3'b111);
        checkOutput("lock_drain1", 64'(mst_bus.wready), 64'b010);
        nextCycle();
        applyStimulus(3'b000, 3'b111, 3'b111);
        checkOutput("lock_drain0", 64'(mst_bus.wready), 64'b001);
        nextCycle();

        // AW order 2 then 0; master 0 W waits behind master 2's 4-beat burst
        applyStimulus(3'b100, 3'b001, 3'b001);
        checkOutput("ord_aw2",     64'(mst_bus.awready), 64'b100);
        checkOutput("ord_wvalid0", 64'(slv_bus.wvalid),  64'd0);
        nextCycle();
        applyStimulus(3'b001, 3'b001, 3'b001);
        checkOutput("ord_aw0",     64'(mst_bus.awready), 64'b001);
        checkOutput("ord_wvalid1", 64'(slv_bus.wvalid),  64'd0);
        nextCycle();
        applyStimulus(3'b000, 3'b001, 3'b001);
        checkOutput("ord_wvalid2", 64'(slv_bus.wvalid), 64'd0);
        for (int b = 0; b < 4; b++) begin
            mst_bus.wch = {43'(200 + b), 43'd101, 43'd100};
            applyStimulus(3'b000, 3'b101, (b == 3) ? 3'b101 : 3'b001);
            checkOutput("burst_wready", 64'(mst_bus.wready), 64'b100);
            checkOutput("burst_wch",    64'(slv_bus.wch),    64'(200 + b));
            nextCycle();
        end
        applyStimulus(3'b000, 3'b001, 3'b001);
        checkOutput("ord_m0_wready", 64'(mst_bus.wready), 64'b001);
        checkOutput("ord_m0_wch",    64'(slv_bus.wch),    64'd100);
        nextCycle();
        applyStimulus(3'b000, 3'b000, 3'b000);

        // B and R routing by tag
        slv_bus.bvalid = 1'b1; slv_bus.bch = 8'h08; mst_bus.bready = 3'b010;
        #1;
        checkOutput("b_tag2_valid", 64'(mst_bus.bvalid), 64'b010);
        checkOutput("b_tag2_ready", 64'(slv_bus.bready), 64'd1);
        mst_bus.bready = 3'b101;
        #1;
        checkOutput("b_tag2_notready", 64'(slv_bus.bready), 64'd0);
        slv_bus.bch = 8'h03;
        #1;
        checkOutput("b_tag0_valid", 64'(mst_bus.bvalid), 64'd0);
        checkOutput("b_tag0_ready", 64'(slv_bus.bready), 64'd1);
        slv_bus.bvalid = 1'b0;
        slv_bus.rvalid = 1'b1; slv_bus.rlast = 1'b1; slv_bus.rch = 41'h1230C; mst_bus.rready = 3'b100;
        #1;
        checkOutput("r_tag3_valid", 64'(mst_bus.rvalid), 64'b100);
        checkOutput("r_tag3_last",  64'(mst_bus.rlast),  64'b100);
        checkOutput("r_tag3_ready", 64'(slv_bus.rready), 64'd1);
        checkOutput("r_payload",    64'(mst_bus.rch),    64'h1230C);
        slv_bus.rvalid = 1'b0; slv_bus.rlast = 1'b0;

        // AR arbitration starts after master 2 (reset pointer)
        slv_bus.arready = 1'b1; mst_bus.arvalid = 3'b110;
        #1;
        checkOutput("ar_first", 64'(mst_bus.arready), 64'b010);
        checkOutput("ar_arch",  64'(slv_bus.arch),    64'd401);
        nextCycle();
        checkOutput("ar_second", 64'(mst_bus.arready), 64'b100);
        nextCycle();
        mst_bus.arvalid = '0;

        // No same-cycle AW-to-W path, then reset mid-burst
        applyStimulus(3'b001, 3'b001, 3'b000);
        checkOutput("nobypass_awready", 64'(mst_bus.awready), 64'b001);
        checkOutput("nobypass_wvalid",  64'(slv_bus.wvalid),  64'd0);
        nextCycle();
        applyStimulus(3'b000, 3'b001, 3'b000);
        checkOutput("mid_wvalid", 64'(slv_bus.wvalid), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        checkOutput("rstmid_wvalid", 64'(slv_bus.wvalid), 64'd0);
        checkOutput("rstmid_wready", 64'(mst_bus.wready), 64'd0);
        nextCycle();
        aresetn = 1'b1;
        nextCycle();
        applyStimulus(3'b000, 3'b001, 3'b000);
        checkOutput("post_rst_wvalid", 64'(slv_bus.wvalid), 64'd0);
        applyStimulus(3'b111, 3'b000, 3'b000);
        checkOutput("post_rst_awready", 64'(mst_bus.awready), 64'b001);
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
